// File: rtl/des_pkg.sv
// DES f-function tables: S-box rows, P permutation and controller state encoding.
// Latency: n/a (package, helper functions are purely combinational).
// Backpressure: n/a.
package des_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Index {box[2:0], row[1:0]}; each row holds 16 nibbles, column 0 in the top nibble.
  localparam logic [0:31][63:0] SBOX_ROWS = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Output bit i+1 takes pre-permutation bit P_TAB[i] (DES numbering, 1-based).
  localparam logic [0:31][5:0] P_TAB = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // box: 0..7 selects S1..S8; v[5] is b1, v[0] is b6.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] v);
    logic [63:0] r;
    r = SBOX_ROWS[{box, v[5], v[0]}];
    r = r << {v[4:1], 2'b00};
    return r[63:60];
  endfunction

  // s[1] and the result's bit 1 are DES bit 1.
  function automatic logic [32:1] p_perm(input logic [32:1] s);
    logic [32:1] r;
    r = '0;
    for (int i = 1; i <= 32; i++) r[i] = s[P_TAB[i-1]];
    return r;
  endfunction

endpackage

// File: rtl/des_sbox.sv
// Single DES S-box lookup, box selected at run time.
// Latency: combinational.
// Backpressure: none (no state).
module des_sbox
  import des_pkg::*;
(
  input  logic [2:0] box_i,
  input  logic [5:0] val_i,
  output logic [3:0] res_o
);

  assign res_o = sbox_lookup(box_i, val_i);

endmodule

// File: rtl/des_sp_unit.sv
// DES f-function back end: S-box substitution of a 48-bit block then P permutation.
// Latency: 8 cycles transfer-to-out_valid (1 cycle when DES_SP_PARALLEL_EN is defined).
// Backpressure: one block in flight; in_ready low until the held result is taken with out_ready.
module des_sp_unit
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:1] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] out_data
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [48:1] in_q;
  logic [32:1] s_q, s_d;
  logic [32:1] out_q, out_d;
  logic        in_ready_q, out_valid_q;
  logic        last_step;

`ifdef DES_SP_PARALLEL_EN
  logic [3:0] sb_res [8];

  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] v;
    assign v = {in_q[6*j+1], in_q[6*j+2], in_q[6*j+3], in_q[6*j+4], in_q[6*j+5], in_q[6*j+6]};
    des_sbox u_sbox (.box_i(3'(j)), .val_i(v), .res_o(sb_res[j]));
  end

  // Assemble all eight nibbles at once; the only BUSY cycle is also the last.
  always_comb begin
    s_d = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 4; k++) s_d[4*j+1+k] = sb_res[j][3-k];
    last_step = 1'b1;
  end
`else
  logic [5:0] sb_val;
  logic [3:0] sb_res;

  des_sbox u_sbox (.box_i(cnt_q), .val_i(sb_val), .res_o(sb_res));

  // Pick the 6-bit group of box cnt_q+1 and merge its nibble into the running s value.
  always_comb begin
    sb_val = '0;
    s_d    = s_q;
    for (int j = 0; j < 8; j++) begin
      if (cnt_q == 3'(j)) begin
        for (int k = 0; k < 6; k++) sb_val[5-k] = in_q[6*j+k+1];
        for (int k = 0; k < 4; k++) s_d[4*j+1+k] = sb_res[3-k];
      end
    end
    last_step = (cnt_q == 3'd7);
  end
`endif

  // Permute the completed s value so the final BUSY edge can register the result.
  always_comb begin
    out_d = p_perm(s_d);
  end

  // Handshake FSM; out_data only moves when a finished result is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      s_q         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_q       <= in_data;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          s_q   <= s_d;
          cnt_q <= cnt_q + 3'd1;
          if (last_step) begin
            out_q       <= out_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_des_sp_unit.sv
// Directed and random checks of des_sp_unit against hand-derived f-function values.
// Latency: expects 8 cycles (1 with DES_SP_PARALLEL_EN).
// Backpressure: exercises DONE hold with out_ready low and in_valid ignored while busy.
module tb_des_sp_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [48:1] in_data;
  logic [32:1] out_data;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DES_SP_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 8;
`endif

  localparam logic [63:0] SB_TAB [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam int P_REF [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  always #5 clk = ~clk;

  des_sp_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Words are held MSB = DES bit 1; ports carry DES bit 1 at index 1.
  function automatic logic [48:1] to_port(input logic [47:0] x);
    logic [48:1] p;
    for (int i = 1; i <= 48; i++) p[i] = x[48-i];
    return p;
  endfunction

  function automatic logic [31:0] from_port(input logic [32:1] p);
    logic [31:0] w;
    for (int i = 1; i <= 32; i++) w[32-i] = p[i];
    return w;
  endfunction

  function automatic logic [31:0] ref_f(input logic [47:0] x);
    logic [31:0] s, r;
    logic [5:0]  six;
    logic [63:0] row;
    int          col;
    s = '0;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      six = x[47-6*j -: 6];
      row = SB_TAB[4*j + 2*int'(six[5]) + int'(six[0])];
      col = int'(six[4:1]);
      s[31-4*j -: 4] = row[63-4*col -: 4];
    end
    for (int i = 0; i < 32; i++) r[31-i] = s[32-P_REF[i]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < limit) begin
      step();
      lat++;
    end
  endtask

  // Assumes IDLE; returns result (DES order) and cycles from transfer to out_valid.
  task automatic run_block(input logic [47:0] x, output logic [31:0] res, output int lat);
    in_data  = to_port(x);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(40, lat);
    res       = from_port(out_data);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, first, got;
    logic [47:0] cur_x;
    logic [31:0] expq [$];
    logic        acc_in, acc_out;
    int          lat, bad, sent, recv, cyc;

    // Reset with a competing input transfer: reset must win.
    rst_n = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
    step(); step();
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();

    // Zero block, then hold in DONE for 20 cycles with junk on the input side.
    in_data = to_port(48'h0); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    wait_valid(40, lat);
    check("zero_latency", 64'(lat), 64'(LAT));
    first = from_port(out_data);
    check("zero_result", 64'(first), 64'h0000_0000_D8D8_DBBC);
    check("done_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = to_port(48'h1234_5678_9ABC);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || from_port(out_data) !== first || in_ready !== 1'b0) bad++;
    end
    check("done_hold_bad_cycles", 64'(bad), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("accept_out_valid", 64'(out_valid), 64'd0);
    check("accept_in_ready",  64'(in_ready),  64'd1);
    check("accept_data_held", 64'(from_port(out_data)), 64'h0000_0000_D8D8_DBBC);

    // All-ones block: every box at row 3 column 15.
    run_block(48'hFFFF_FFFF_FFFF, res, lat);
    check("ones_latency", 64'(lat), 64'(LAT));
    check("ones_result",  64'(res), 64'h0000_0000_38DB_F9CB);

    // Box 1 input 011011 -> nibble 5 instead of E.
    run_block({6'b011011, 42'h0}, res, lat);
    check("s1_011011_result", 64'(res), 64'h0000_0000_D858_D9BE);

    // New block offered throughout BUSY/DONE must not disturb the zero-block result.
    in_data = to_port(48'h0); in_valid = 1'b1;
    step();
    in_data = to_port(48'hFFFF_0000_FFFF);
    wait_valid(40, lat);
    in_valid = 1'b0;
    check("busy_ignore_result", 64'(from_port(out_data)), 64'h0000_0000_D8D8_DBBC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("busy_ignore_idle", 64'(in_ready), 64'd1);

    // Reset on the fourth BUSY cycle aborts the block.
    in_data = to_port(48'hA5A5_5A5A_0F0F); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data",  64'(out_data),  64'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_valid", 64'(bad), 64'd0);
    run_block(48'h0, res, lat);
    check("after_abort_result", 64'(res), 64'h0000_0000_D8D8_DBBC);

    // Random traffic with random handshakes, checked in order against the model.
    sent = 0; recv = 0; cyc = 0;
    cur_x = {16'($urandom), 32'($urandom)};
    while (recv < 1000 && cyc < 60000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = to_port(cur_x);
      out_ready = ($urandom_range(0, 3) != 0);
      acc_in    = in_valid && in_ready;
      acc_out   = out_valid && out_ready;
      got       = from_port(out_data);
      step();
      cyc++;
      if (acc_in) begin
        expq.push_back(ref_f(cur_x));
        sent++;
        cur_x = {16'($urandom), 32'($urandom)};
      end
      if (acc_out) begin
        recv++;
        if (expq.size() == 0) check("rand_unexpected_output", 64'd1, 64'd0);
        else check("rand_result", 64'(got), 64'(expq.pop_front()));
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_received", 64'(recv), 64'd1000);
    check("rand_leftover", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
